// File: rtl/booth_pkg.sv
// booth_pkg: shared state/digit types and the radix-4 digit decode table.
package booth_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
  typedef logic signed [2:0] digit_t;
  // Each entry is {neg, two, zero}, indexed by the 3-bit overlapping multiplier group.
  localparam logic [2:0] ENC_TAB [8] = '{
    3'b001, 3'b000, 3'b000, 3'b010,
    3'b110, 3'b100, 3'b100, 3'b001
  };
endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc: combinational radix-4 Booth group decode to {neg, two, zero}.
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] i_grp,
  output logic       o_neg,
  output logic       o_two,
  output logic       o_zero
);
  assign {o_neg, o_two, o_zero} = ENC_TAB[i_grp];
endmodule

// File: rtl/booth_r4_mul.sv
// booth_r4_mul: sequential signed radix-4 Booth multiplier, GO/done handshake.
// Define BOOTH_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH / 2) + 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               GO,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done,
  output logic [1:0]         CS
);
  if (WIDTH < 4 || WIDTH % 2 != 0) begin : g_bad_width
    $error("booth_r4_mul: WIDTH must be even and >= 4");
  end
  state_t             r_cs, w_ns;
  logic [2*WIDTH-1:0] r_mcand, r_acc, r_p, w_mag, w_acc_nxt;
  logic [WIDTH:0]     r_mplr, w_mplr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_neg, w_two, w_zero, w_last, w_fin;
  booth_r4_enc u_enc (
    .i_grp  (r_mplr[2:0]),
    .o_neg  (w_neg),
    .o_two  (w_two),
    .o_zero (w_zero)
  );
  assign w_mag      = w_zero ? '0 : w_two ? r_mcand << 1 : r_mcand;
  assign w_acc_nxt  = r_acc + (w_neg ? -w_mag : w_mag);
  assign w_mplr_nxt = {{2{r_mplr[WIDTH]}}, r_mplr[WIDTH:2]};
  assign w_last     = r_cnt == CNT_W'(WIDTH / 2 - 1);
`ifdef BOOTH_EARLY_TERM_EN
  // An all-zero or all-one shifted multiplier only yields zero digits from here on.
  assign w_fin = w_last | ~|w_mplr_nxt | &w_mplr_nxt;
`else
  assign w_fin = w_last;
`endif
  always_comb begin
    w_ns = IDLE;
    case (r_cs)
      IDLE:    w_ns = GO ? CALC : IDLE;
      CALC:    w_ns = w_fin ? DONE : CALC;
      default: w_ns = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      r_cs    <= IDLE;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      r_cs <= w_ns;
      if (r_cs == IDLE && GO) begin
        r_mcand <= {{WIDTH{A[WIDTH-1]}}, A};
        r_mplr  <= {B, 1'b0};
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_cs == CALC) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 2;
        r_mplr  <= w_mplr_nxt;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_fin) r_p <= w_acc_nxt;
      end
    end
  end
  assign P    = r_p;
  assign CS   = r_cs;
  assign busy = r_cs == CALC || r_cs == DONE;
  assign done = r_cs == DONE;
endmodule

// File: tb/tb_booth_r4_mul.sv
// tb_booth_r4_mul: randomized and directed checks of booth_r4_mul against a signed-arithmetic model.
module tb_booth_r4_mul;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           RST, GO;
  logic [W-1:0]   A, B;
  logic [2*W-1:0] P;
  logic           busy, done;
  logic [1:0]     CS;
  int             n_tests = 0;
  int             n_fail = 0;
  booth_r4_mul #(.WIDTH(W)) dut (
    .clk  (clk),
    .RST  (RST),
    .GO   (GO),
    .A    (A),
    .B    (B),
    .P    (P),
    .busy (busy),
    .done (done),
    .CS   (CS)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction
  function automatic int calc_cycles(input logic [W-1:0] b);
    int bi;
    bi = int'($signed(b));
`ifdef BOOTH_EARLY_TERM_EN
    for (int k = 1; k < W / 2; k++)
      if ((bi >>> (2 * k - 1)) == 0 || (bi >>> (2 * k - 1)) == -1) return k;
`endif
    return W / 2 + 0 * bi;
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n, nb, k;
    k = calc_cycles(b);
    @(negedge clk);
    A = a; B = b; GO = 1'b1;
    @(posedge clk);
    #1 GO = 1'b0;
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      nb += int'(busy);
    end while (!done && n < 20);
    chk("latency", 64'(n), 64'(k + 1));
    chk("busy_cycles", 64'(nb), 64'(k + 1));
    chk("product", 64'(P), 64'(prod(a, b)));
    @(negedge clk);
    chk("done_pulse", {61'd0, done, CS}, 64'd0);
  endtask
  initial begin
    logic [W-1:0] qa[$], qb[$];
    logic [W-1:0] a, b;
    int ndone, prev, nres;
    RST = 1'b1; GO = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {44'd0, CS, P, busy, done}, 64'd0);
    RST = 1'b0;
    run_op(8'd7, -8'sd3);
    run_op(8'h80, 8'h80);
    run_op(8'h80, 8'h7F);
    run_op(8'h7F, 8'h7F);
    run_op(8'd77, 8'd0);
    run_op(-8'sd5, 8'd1);
    run_op(8'd9, 8'hFF);
    run_op(8'h80, 8'h01);
    // GO re-asserted throughout CALC and DONE must not start a second operation.
    @(negedge clk);
    A = 8'd7; B = -8'sd3; GO = 1'b1;
    @(posedge clk);
    #1 A = 8'd5; B = 8'd5;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      ndone += int'(done);
      GO = CS != 2'd0;
    end
    chk("ignored_go_dones", 64'(ndone), 64'd1);
    chk("ignored_go_prod", 64'(P), 64'(prod(8'd7, -8'sd3)));
    // Reset during the second CALC cycle aborts the operation.
    @(negedge clk);
    A = 8'd100; B = 8'hB3; GO = 1'b1;
    @(posedge clk);
    #1 GO = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    chk("abort_state", {44'd0, CS, P, busy, done}, 64'd0);
    RST = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(8'd100, 8'hB3);
    // GO held high: back-to-back results, each matched to its own operands.
    @(negedge clk);
    GO = 1'b1;
    prev = -1; nres = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        a = qa.pop_front(); b = qb.pop_front();
        chk("held_prod", 64'(P), 64'(prod(a, b)));
        if (prev >= 0) chk("held_interval", 64'(c - prev), 64'(calc_cycles(b) + 2));
        prev = c; nres++;
      end
      if (CS == 2'd0) begin
        a = W'($urandom); b = W'($urandom);
        A = a; B = b;
        qa.push_back(a); qb.push_back(b);
      end
    end
    GO = 1'b0;
    chk("held_results", 64'(nres >= 6), 64'd1);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 1000; i++) run_op(W'($urandom), W'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
